// File: rtl/comp_search.sv
// rtl/comp_search.sv - binary search driver for an external 3-way comparator
// Narrows [lo,hi] around the target using x/y/z responses; all outputs registered.
module comp_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  output logic             req,
  input  logic             ack,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [3:0]       steps
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] lo, hi;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mid, guess_inc, guess_dec;

  // Extra sum bit keeps lo+hi from wrapping before the halving.
  assign sum       = {1'b0, lo} + {1'b0, hi};
  assign mid       = WIDTH'(sum >> 1);
  assign guess_inc = guess + ONE;
  assign guess_dec = guess - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      lo     <= '0;
      hi     <= MAXV;
      guess  <= '0;
      req    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      result <= '0;
      err    <= 1'b0;
      steps  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lo     <= '0;
            hi     <= MAXV;
            steps  <= 4'd0;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            busy   <= 1'b1;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          guess <= mid;
          req   <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (ack) begin
            req <= 1'b0;
            if (steps != 4'd15) steps <= steps + 4'd1;
            // A bound update that empties the range means the responder lied.
            case ({x, y, z})
              3'b100: begin
                if (guess == MAXV || guess_inc > hi) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end else begin
                  lo    <= guess_inc;
                  state <= S_ISSUE;
                end
              end
              3'b010: begin
                if (guess == '0 || guess_dec < lo) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end else begin
                  hi    <= guess_dec;
                  state <= S_ISSUE;
                end
              end
              3'b001: begin
                result <= guess;
                found  <= 1'b1;
                state  <= S_DONE;
                done   <= 1'b1;
              end
              default: begin
                err   <= 1'b1;
                found <= 1'b0;
                state <= S_DONE;
                done  <= 1'b1;
              end
            endcase
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
